router_1xn: RTL

- Parametrised single-input, N-output packet router: next generation of the 1x3 router.
- Accepts framed packets on one byte-stream input, steers each packet to one of NUM_PORTS internal FIFOs by header address, and checks trailing parity.
- New over the 1x3 router: configurable width, depth and port count; length-based framing that tolerates input gaps; first-word-fall-through outputs; invalid-address drop; configurable read timeout flush.
- Self-contained; sits between the packet source and NUM_PORTS downstream consumers.

---
 rtl/router_1xn.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/router_1xn.sv
// router_1xn: single byte-stream input steered by header address into
// NUM_PORTS first-word-fall-through FIFOs, with length framing, parity check,
// invalid-address drop and per-port read-timeout flush.
// Optional: define ROUTER_STATS_EN to add err_cnt/drop_cnt statistics outputs.
module router_1xn #(
    parameter int DATA_W     = 8,
    parameter int NUM_PORTS  = 3,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 30
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic                        pkt_valid,
    input  logic [DATA_W-1:0]           data_in,
    output logic                        busy,
    output logic                        err,
    input  logic [NUM_PORTS-1:0]        rd_en,
    output logic [NUM_PORTS-1:0]        vld_out,
    output logic [NUM_PORTS*DATA_W-1:0] data_out
`ifdef ROUTER_STATS_EN
    ,
    output logic [15:0]                 err_cnt,
    output logic [15:0]                 drop_cnt
`endif
);

    localparam int ADDR_W = ($clog2(NUM_PORTS) < 1) ? 1 : $clog2(NUM_PORTS);
    localparam int NSLOT  = 1 << ADDR_W;
    localparam int LEN_W  = DATA_W - ADDR_W;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = AW + 1;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_PARITY, S_DROP} state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_dest, w_dest_nxt;
    logic [LEN_W-1:0]    r_remain, w_remain_nxt;
    logic [DATA_W-1:0]   r_parity, w_parity_nxt;
    logic                r_err;

    logic [PTR_W-1:0]    r_wr_ptr [NUM_PORTS];
    logic [PTR_W-1:0]    r_rd_ptr [NUM_PORTS];
    logic [CNT_W-1:0]    r_cnt    [NUM_PORTS];
    logic [DATA_W-1:0]   r_mem    [NUM_PORTS][FIFO_DEPTH];

    logic [NSLOT-1:0]    w_full, w_flush;
    logic [NUM_PORTS-1:0] w_empty, w_pop, w_push;
    logic [ADDR_W-1:0]   w_addr, w_wr_port;
    logic                w_addr_ok, w_busy, w_accept, w_wr_en, w_bad_hdr, w_par_err;

    assign w_addr    = data_in[ADDR_W-1:0];
    assign w_addr_ok = int'(w_addr) < NUM_PORTS;
    assign w_accept  = pkt_valid && !w_busy;
    assign busy      = w_busy;
    assign err       = r_err;

    // Per-port FIFO status, timeout detection and FWFT head presentation
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_full   = '0;
        w_flush  = '0;
        w_empty  = '0;
        w_pop    = '0;
        vld_out  = '0;
        data_out = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_empty[i] = (r_wr_ptr[i] == r_rd_ptr[i]);
            w_full[i]  = (r_wr_ptr[i] == (r_rd_ptr[i] ^ {1'b1, {AW{1'b0}}}));
            w_pop[i]   = rd_en[i] && !w_empty[i];
            w_flush[i] = !w_empty[i] && !rd_en[i] && (r_cnt[i] == CNT_W'(TIMEOUT));
            vld_out[i] = !w_empty[i];
            if (!w_empty[i])
                data_out[i*DATA_W +: DATA_W] = r_mem[i][r_rd_ptr[i][AW-1:0]];
        end
    end

    // Backpressure: full status is taken before any same-cycle pop
    always_comb begin
        w_busy = 1'b0;
        case (r_state)
            S_IDLE:              w_busy = pkt_valid && w_addr_ok && w_full[w_addr];
            S_PAYLOAD, S_PARITY: w_busy = w_full[r_dest];
            default:             w_busy = 1'b0;
        endcase
    end

    // Next-state, framing and parity logic
    always_comb begin
        w_state_nxt  = r_state;
        w_dest_nxt   = r_dest;
        w_remain_nxt = r_remain;
        w_parity_nxt = r_parity;
        w_wr_en      = 1'b0;
        w_wr_port    = r_dest;
        w_bad_hdr    = 1'b0;
        w_par_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_dest_nxt   = w_addr;
                    w_remain_nxt = data_in[DATA_W-1:ADDR_W];
                    w_parity_nxt = data_in;
                    if (w_addr_ok) begin
                        w_wr_en     = 1'b1;
                        w_wr_port   = w_addr;
                        w_state_nxt = (data_in[DATA_W-1:ADDR_W] == '0) ? S_PARITY : S_PAYLOAD;
                        // A header landing on a port being flushed loses the whole packet
                        if (w_flush[w_addr]) w_state_nxt = S_DROP;
                    end else begin
                        w_bad_hdr   = 1'b1;
                        w_state_nxt = S_DROP;
                    end
                end
            end
            S_PAYLOAD: begin
                if (w_accept) begin
                    w_wr_en      = 1'b1;
                    w_parity_nxt = r_parity ^ data_in;
                    w_remain_nxt = r_remain - LEN_W'(1);
                    if (r_remain == LEN_W'(1)) w_state_nxt = S_PARITY;
                end
                // Remaining payload count carries over so DROP still ends on the parity word
                if (w_flush[r_dest]) w_state_nxt = S_DROP;
            end
            S_PARITY: begin
                if (w_accept) begin
                    w_wr_en     = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_par_err   = (data_in != r_parity) && !w_flush[r_dest];
                end else if (w_flush[r_dest]) begin
                    w_state_nxt = S_DROP;
                end
            end
            default: begin
                if (w_accept) begin
                    if (r_remain == '0) w_state_nxt = S_IDLE;
                    else                w_remain_nxt = r_remain - LEN_W'(1);
                end
            end
        endcase
    end

    // Decode the single write port into per-FIFO push strobes
    always_comb begin
        w_push = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            w_push[i] = w_wr_en && (int'(w_wr_port) == i);
    end

    // FSM state and packet context registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_dest   <= '0;
            r_remain <= '0;
            r_parity <= '0;
            r_err    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state  <= w_state_nxt;
            r_dest   <= w_dest_nxt;
            r_remain <= w_remain_nxt;
            r_parity <= w_parity_nxt;
            r_err    <= w_bad_hdr || w_par_err;
        end
    end

    // FIFO pointers and read-timeout counters; a flush snaps rd onto wr
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_flush[i]) begin
                    r_rd_ptr[i] <= r_wr_ptr[i];
                    r_cnt[i]    <= '0;
                end else begin
                    if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + PTR_W'(1);
                    if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + PTR_W'(1);
                    if (!w_empty[i] && !rd_en[i]) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    else                          r_cnt[i] <= '0;
                end
            end
        end
    end

    // FIFO storage writes
    // NOTE: storage has no reset; pointers alone define which entries are valid.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_PORTS; i++)
            if (w_push[i] && !w_flush[i])
                r_mem[i][r_wr_ptr[i][AW-1:0]] <= data_in;
    end

`ifdef ROUTER_STATS_EN
    logic [15:0] r_err_cnt, r_drop_cnt;
    logic [4:0]  w_drop_inc;
    logic [16:0] w_drop_sum;

    assign err_cnt  = r_err_cnt;
    assign drop_cnt = r_drop_cnt;

    // Number of drop events this cycle: bad header plus any timeout flushes
    always_comb begin
        w_drop_inc = {4'b0, w_bad_hdr};
        for (int i = 0; i < NUM_PORTS; i++)
            w_drop_inc = w_drop_inc + 5'(w_flush[i]);
        w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_drop_inc);
    end

    // Saturating statistics counters
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_err_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_par_err && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
            r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end
`endif

endmodule
